// File: rtl/relu_backward.sv
// ReLU backward gate: records a sign mask per forward activation, then zeroes gradients whose activation was negative.
// One-cycle registered gradient latency; fwd/grad ready derive from registered state (grad also from out_ready).
module relu_backward #(
  parameter int c     = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fwd_valid,
  input  logic [c-1:0]               fwd_in,
  output logic                       fwd_ready,
  input  logic                       grad_valid,
  input  logic [c-1:0]               grad_in,
  output logic                       grad_ready,
  output logic                       out_valid,
  output logic [c-1:0]               grad_out,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            load;
  logic [DEPTH-1:0] mask_mem;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Ready terms never look at the incoming valids, so a push into an empty buffer cannot be popped in the same cycle.
  assign fwd_ready  = rst_n && !full;
  assign grad_ready = rst_n && !empty && (!out_valid || out_ready);

  assign push = fwd_valid && fwd_ready;
  assign pop  = grad_valid && grad_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (pop) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mask bit is the inverted sign: zero counts as non-negative.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_mem <= '0;
      wr_ptr   <= '0;
    end else if (push) begin
      mask_mem[wr_ptr] <= ~fwd_in[c-1];
      wr_ptr           <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grad_out <= '0;
    end else if (load) begin
      grad_out <= mask_mem[rd_ptr] ? grad_in : '0;
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// Scoreboard bench for relu_backward: drivers queue hand-computed gradients, a negedge monitor checks outputs.
module tb_relu_backward;

  localparam int W = 10;
  localparam int D = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                fwd_valid;
  logic signed [W-1:0] fwd_in;
  logic                fwd_ready;
  logic                grad_valid;
  logic signed [W-1:0] grad_in;
  logic                grad_ready;
  logic                out_valid;
  logic signed [W-1:0] grad_out;
  logic                out_ready;
  logic [2:0]          count;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  relu_backward #(.c(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_ready(fwd_ready),
    .grad_valid(grad_valid), .grad_in(grad_in), .grad_ready(grad_ready),
    .out_valid(out_valid), .grad_out(grad_out), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", int'(grad_out), 99999);
      end else begin
        chk("grad_out", int'(grad_out), exp_q.pop_front());
      end
    end
  end

  task automatic push(input int v);
    bit ok = 0;
    fwd_valid = 1'b1;
    fwd_in = W'(v);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (fwd_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    fwd_valid = 1'b0;
    if (!ok) chk("push_accept", int'(ok), 1);
  endtask

  task automatic send_grad(input int g, input int e);
    bit ok = 0;
    grad_valid = 1'b1;
    grad_in = W'(g);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (grad_ready) ok = 1;
      @(posedge clk);
      if (ok) exp_q.push_back(e);
      #1;
    end
    grad_valid = 1'b0;
    if (!ok) chk("grad_accept", int'(ok), 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_grad_out"}, int'(grad_out), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_fwd_ready"}, int'(fwd_ready), 1);
    chk({tag, "_grad_ready"}, int'(grad_ready), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    fwd_valid = 1'b0;
    fwd_in = '0;
    grad_valid = 1'b0;
    grad_in = '0;
    out_ready = 1'b1;

    // Reset held for two cycles
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_fwd_ready_low", int'(fwd_ready), 0);
    chk("rst_grad_ready_low", int'(grad_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_values("reset");
    @(posedge clk); #1;

    // Masking and full: 5 -> 1, -3 -> 0, 0 -> 1, -512 -> 0
    push(5); push(-3); push(0); push(-512);
    @(negedge clk);
    chk("full_count", int'(count), 4);
    chk("full_fwd_ready", int'(fwd_ready), 0);
    fwd_valid = 1'b1;
    fwd_in = 10'sd7;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("full_no_write", int'(count), 4);
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    send_grad(100, 100);
    send_grad(100, 0);
    send_grad(-7, -7);
    send_grad(511, 0);
    drain("mask_drain");
    @(negedge clk);
    chk("mask_count_end", int'(count), 0);
    @(posedge clk); #1;

    // Simultaneous pop and push from count 3: masks -1:0, 2:1, 3:1, then -4:0
    push(-1); push(2); push(3);
    @(negedge clk);
    chk("pp_count_before", int'(count), 3);
    @(posedge clk); #1;
    fwd_valid = 1'b1; fwd_in = -10'sd4;
    grad_valid = 1'b1; grad_in = 10'sd10;
    @(negedge clk);
    chk("pp_fwd_ready", int'(fwd_ready), 1);
    chk("pp_grad_ready", int'(grad_ready), 1);
    @(posedge clk);
    exp_q.push_back(0);
    #1;
    fwd_valid = 1'b0;
    grad_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_after", int'(count), 3);
    @(posedge clk); #1;
    send_grad(20, 20);
    send_grad(30, 30);
    send_grad(40, 0);
    drain("pp_drain");

    // Backpressure: output held for 5 cycles while out_ready is low
    out_ready = 1'b0;
    push(1); push(2); push(-3); push(4);
    send_grad(55, 55);
    grad_valid = 1'b1;
    grad_in = 10'sd66;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_grad_ready", int'(grad_ready), 0);
      chk("bp_grad_out_stable", int'(grad_out), 55);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_grad(66, 66);
    send_grad(77, 0);
    send_grad(88, 88);
    drain("bp_drain");
    @(negedge clk);
    chk("bp_count_end", int'(count), 0);
    chk("bp_out_valid_end", int'(out_valid), 0);
    @(posedge clk); #1;

    // Empty: no bypass of a same-cycle push
    fwd_valid = 1'b1; fwd_in = 10'sd8;
    grad_valid = 1'b1; grad_in = 10'sd9;
    @(negedge clk);
    chk("nb_grad_ready_empty", int'(grad_ready), 0);
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    @(negedge clk);
    chk("nb_count", int'(count), 1);
    chk("nb_grad_ready_next", int'(grad_ready), 1);
    @(posedge clk);
    exp_q.push_back(9);
    #1;
    grad_valid = 1'b0;
    @(negedge clk);
    chk("nb_out_valid", int'(out_valid), 1);
    drain("nb_drain");

    // Reset mid-run with count 3 and a pending output
    out_ready = 1'b0;
    push(1); push(1); push(1); push(1);
    send_grad(5, 5);
    @(negedge clk);
    chk("mr_count_pre", int'(count), 3);
    chk("mr_out_valid_pre", int'(out_valid), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(-1);
    send_grad(42, 0);
    drain("mr_drain");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/relu_backward.md
# relu_backward

Streaming backward-pass companion to the network's combinational ReLU stage. During the forward pass it records one mask bit per activation: 1 if the activation input was non-negative, 0 if negative. During the backward pass it consumes upstream gradients in the same order and forwards each gradient unchanged when its mask bit is 1, or forces it to 0 when the mask bit is 0. It sits between the forward activation datapath and the gradient return path, with valid/ready handshakes on all three streams.

## Interface
- c, 10: data width of activations and gradients (two's complement).
- DEPTH, 16: mask buffer entries; power of two, ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- fwd_valid  input  1  forward activation present.
- fwd_in  input  c  signed forward activation (ReLU d_in).
- fwd_ready  output  1  mask buffer can accept.
- grad_valid  input  1  upstream gradient present.
- grad_in  input  c  signed upstream gradient.
- grad_ready  output  1  gradient can be accepted.
- out_valid  output  1  gated gradient present.
- grad_out  output  c  signed gated gradient.
- out_ready  input  1  downstream accepts grad_out.
- count  output  $clog2(DEPTH+1)  mask bits currently stored.

## Operation
- The mask buffer is a 1-bit FIFO of DEPTH entries with read and write pointers that wrap at DEPTH.
- **Push:** when fwd_valid && fwd_ready, write mask = !(fwd_in < 0) at the write pointer and advance the pointer. fwd_in = 0 gives mask 1. fwd_ready = (count != DEPTH).
- **Pop:** when grad_valid && grad_ready, read the mask at the read pointer, advance the pointer, load grad_out ← mask ? grad_in : 0, and set out_valid.
- grad_ready = (count != 0) && (!out_valid || out_ready).
- **Output stage states:**
  - IDLE (out_valid = 0): goes to HOLD on a pop.
  - HOLD (out_valid = 1): if out_ready && pop, reload and stay in HOLD. If out_ready && !pop, go to IDLE. If !out_ready, stay in HOLD with grad_out stable.
- **Occupancy:**
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
- **No bypass:** a push into an empty buffer cannot be popped in the same cycle.
- **Full:** fwd_ready = 0 regardless of a pop that cycle. No write occurs and no data is lost; the producer must hold fwd_valid.
- **Empty:** grad_ready = 0 and gradients are stalled.
- fwd_ready and grad_ready are functions of registered state only and never depend combinationally on fwd_valid or grad_valid.
- **Reset** (rst_n = 0 at a clock edge), including mid-operation:
  - count, both pointers, out_valid, and grad_out all go to 0.
  - Any stored masks and any pending output are discarded.

## Timing
- Reset values: out_valid = 0, grad_out = 0, count = 0, fwd_ready = 1, grad_ready = 0.
- While rst_n = 0, fwd_ready = 0 and grad_ready = 0.
- Latency: a gradient accepted at edge k appears on grad_out with out_valid = 1 after edge k. That is one-cycle registered latency.
- Throughput: one gradient per cycle when out_ready is held high. One push per cycle while not full.
- A pushed mask becomes poppable one cycle after its push edge.
- count is registered and updates at the same edge as the push or pop.

## Test plan
- **Reset:** hold rst_n = 0 for 2 cycles, then release. Expect out_valid = 0, grad_out = 0, count = 0, fwd_ready = 1, grad_ready = 0.
- **Masking** (c = 10, DEPTH = 4): push fwd_in 5, −3, 0, −512, then gradients 100, 100, −7, 511. Expect grad_out 100, 0, −7, 0 in order, with count ending at 0.
- **Full:** push 4 entries. Expect count = 4 and fwd_ready = 0; a 5th fwd_valid is not written. Then do a pop and push in the same cycle from count 3. Expect count to stay 3 and the gated order to be preserved.
- **Backpressure:** with out_valid = 1 and out_ready = 0 for 5 cycles, expect grad_ready = 0 and grad_out stable. Then raise out_ready. Expect one output per cycle with no loss or duplication.
- **Empty / no bypass:** with count = 0, assert fwd_valid and grad_valid together. Expect grad_ready = 0 that cycle, the gradient accepted on the next cycle, and the output one cycle after that.
- **Reset mid-run:** with count = 3 and out_valid = 1, pull rst_n low for 1 cycle. Expect all reset values. A new push of −1 followed by gradient 42 yields 0, confirming that old masks are not reused.
